// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, word type and helpers for the pipelined
// 32-bit adder front end (carry_pipe32 and its cla8_carry blocks).
`timescale 1ns/1ps
package adder_pkg;

  localparam int WIDTH = 32;  // datapath width, fixed by the sum stage
  localparam int BLK   = 8;   // bits per carry-lookahead block
  localparam int NBLK  = 4;   // lookahead blocks across the word

  typedef logic [WIDTH-1:0] word_t;

  // Effective B operand: subtraction is A + ~B + 1, so B is inverted here
  // and the +1 arrives as the forced carry-in.
  function automatic word_t b_eff_f(input word_t b, input logic sub);
    return sub ? ~b : b;
  endfunction

endpackage

// File: rtl/cla8_carry.sv
// cla8_carry: combinational 8-bit carry-lookahead block.
// Ports:
//   p[7:0]  in  per-bit propagate
//   g[7:0]  in  per-bit generate
//   ci      in  block carry-in
//   c[7:0]  out carry out of each bit, c[i] = g[i] | p[i]&c[i-1], c[-1] = ci
`timescale 1ns/1ps
module cla8_carry
  import adder_pkg::*;
(
  input  logic [BLK-1:0] p,
  input  logic [BLK-1:0] g,
  input  logic           ci,
  output logic [BLK-1:0] c
);

  // Flattened sum-of-products form of the ripple recurrence: each carry is
  // the OR of every generate term that can propagate up to bit i, plus the
  // block carry-in when all lower bits propagate. No carry depends on
  // another carry, so the depth stays constant inside the block.
  function automatic logic [BLK-1:0] lookahead_f(
    input logic [BLK-1:0] pv,
    input logic [BLK-1:0] gv,
    input logic           civ
  );
    logic [BLK-1:0] cv;
    logic           term;
    cv = '0;
    for (int i = 0; i < BLK; i++) begin
      term = civ;
      for (int k = 0; k <= i; k++) begin
        term = term & pv[k];
      end
      cv[i] = term;
      for (int j = 0; j <= i; j++) begin
        term = gv[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & pv[k];
        end
        cv[i] = cv[i] | term;
      end
    end
    return cv;
  endfunction

  assign c = lookahead_f(p, g, ci);

endmodule

// File: rtl/carry_pipe32.sv
// carry_pipe32: two-stage pipelined adder front end with valid/ready on both
// sides. S1 registers propagate/generate/effective carry-in; S2 computes the
// carry vector through four 8-bit lookahead blocks (block carry rippled
// between them) and registers p, c, cin_out and ovf.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake (in_ready is combinational)
//   a, b, cin, sub          operands; sub=1 selects a-b and ignores cin
//   out_valid / out_ready   downstream handshake
//   p, c, cin_out, ovf      propagate, carries, effective carry-in, overflow
`timescale 1ns/1ps
module carry_pipe32 #(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] c,
  output logic             cin_out,
  output logic             ovf
);
  import adder_pkg::*;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic             ci1_q, ci1_d;
  logic [WIDTH-1:0] p_q, p_d, c_q, c_d;
  logic             cin_q, cin_d, ovf_q, ovf_d;
  logic             s1_adv_s, s2_adv_s, s1_load_s, s2_load_s;
  logic [WIDTH-1:0] b_eff_s, c_s;

  // A stage may advance when it is empty or its successor advances.
  assign s2_adv_s  = ~v2_q | out_ready;
  assign s1_adv_s  = ~v1_q | s2_adv_s;
  assign s1_load_s = in_valid & s1_adv_s;
  assign s2_load_s = v1_q & s2_adv_s;
  assign b_eff_s   = b_eff_f(b, sub);

  // Each block gets its own carry net so the inter-block ripple is a plain
  // chain rather than a feedback through one shared vector.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic           blk_ci_s;
    logic [BLK-1:0] blk_c_s;
    if (k == 0) begin : g_first
      assign blk_ci_s = ci1_q;
    end else begin : g_next
      assign blk_ci_s = g_blk[k-1].blk_c_s[BLK-1];
    end
    cla8_carry u_cla (
      .p  (p1_q[k*BLK +: BLK]),
      .g  (g1_q[k*BLK +: BLK]),
      .ci (blk_ci_s),
      .c  (blk_c_s)
    );
    assign c_s[k*BLK +: BLK] = blk_c_s;
  end

  // Next-state for both stages: data loads only on its stage's load enable.
  always_comb begin
    v1_d  = v1_q;
    p1_d  = p1_q;
    g1_d  = g1_q;
    ci1_d = ci1_q;
    v2_d  = v2_q;
    p_d   = p_q;
    c_d   = c_q;
    cin_d = cin_q;
    ovf_d = ovf_q;
    if (s1_load_s) begin
      v1_d  = 1'b1;
      p1_d  = a ^ b_eff_s;
      g1_d  = a & b_eff_s;
      ci1_d = sub | cin;
    end else if (s1_adv_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
    if (s2_load_s) begin
      v2_d  = 1'b1;
      p_d   = p1_q;
      c_d   = c_s;
      cin_d = ci1_q;
      ovf_d = c_s[WIDTH-1] ^ c_s[WIDTH-2];
    end else if (s2_adv_s) begin
      v2_d = 1'b0;
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset discards any in-flight bundle.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q  <= 1'b0;
      p1_q  <= '0;
      g1_q  <= '0;
      ci1_q <= 1'b0;
      v2_q  <= 1'b0;
      p_q   <= '0;
      c_q   <= '0;
      cin_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      p1_q  <= p1_d;
      g1_q  <= g1_d;
      ci1_q <= ci1_d;
      v2_q  <= v2_d;
      p_q   <= p_d;
      c_q   <= c_d;
      cin_q <= cin_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = v2_q;
  assign p         = p_q;
  assign c         = c_q;
  assign cin_out   = cin_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_pipe32.sv
// tb_carry_pipe32: directed and randomised self-checking bench for
// carry_pipe32. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_carry_pipe32;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] c;
    logic        ecin;
    logic        eovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cin_out, ovf;
  logic [31:0] a, b, p, c;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  carry_pipe32 #(.WIDTH(32)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .c(c), .cin_out(cin_out), .ovf(ovf)
  );

  // Reference: carries recovered from a full-width sum, c[i] = carry into i+1.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic msub);
    logic [31:0] be;
    logic        ci;
    logic [32:0] s;
    exp_t        r;
    be = msub ? ~mb : mb;
    ci = msub | mcin;
    s  = {1'b0, ma} + {1'b0, be} + {32'd0, ci};
    r.p = ma ^ be;
    r.ecin = ci;
    r.c[31] = s[32];
    for (int i = 0; i < 31; i++) r.c[i] = s[i+1] ^ ma[i+1] ^ be[i+1];
    r.eovf = r.c[31] ^ r.c[30];
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk32({tag, "_p"}, p, e.p);
    chk32({tag, "_c"}, c, e.c);
    chk1({tag, "_cin"}, cin_out, e.ecin);
    chk1({tag, "_ovf"}, ovf, e.eovf);
  endtask

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tcin, input logic tsub);
    in_valid = v;
    a = ta;
    b = tb_;
    cin = tcin;
    sub = tsub;
  endtask

  // One bundle through an idle pipe with out_ready held high.
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tcin, input logic tsub, input exp_t e);
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, ta, tb_, tcin, tsub);
    #1 chk1({tag, "_rdy"}, in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk1({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk_out(tag, e);
  endtask

  logic [31:0] bp_a [4] = '{32'h0000_00FF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_0000};
  logic [31:0] bp_b [4] = '{32'h0000_0001, 32'h8000_0000, 32'h1111_1111, 32'h0001_0000};
  logic        bp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  exp_t        bp_e [4];
  exp_t        q [$];
  exp_t        e;
  int          sent, cyc;

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk32("rst_p", p, 32'd0);
    chk32("rst_c", c, 32'd0);
    chk1("rst_cin", cin_out, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    #1 chk1("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, hand-computed.
    single("add1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0,
           '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0});
    single("sub_eq", 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1,
           '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0});
    single("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           '{32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, 1'b1});
    single("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0});
    single("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0,
           '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0});
    single("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1,
           '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0});
    single("blk_edge", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           '{32'h0000_00FE, 32'h0000_00FF, 1'b0, 1'b0});

    // Back-pressure: two accepts fill the pipe, then hold, then drain in order.
    for (int k = 0; k < 4; k++) bp_e[k] = model(bp_a[k], bp_b[k], 1'b0, bp_s[k]);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, bp_a[0], bp_b[0], 1'b0, bp_s[0]);
    #1 chk1("bp_acc0", in_ready, 1'b1);
    @(negedge clk);
    drive(1'b1, bp_a[1], bp_b[1], 1'b0, bp_s[1]);
    #1 chk1("bp_acc1", in_ready, 1'b1);
    @(negedge clk);
    drive(1'b1, bp_a[2], bp_b[2], 1'b0, bp_s[2]);
    #1 chk1("bp_full", in_ready, 1'b0);
    chk_out("bp_hold0", bp_e[0]);
    @(negedge clk);
    chk1("bp_full2", in_ready, 1'b0);
    chk_out("bp_hold1", bp_e[0]);
    @(negedge clk);
    chk_out("bp_hold2", bp_e[0]);
    out_ready = 1'b1;
    #1 chk1("bp_release", in_ready, 1'b1);
    @(negedge clk);
    chk_out("bp_out1", bp_e[1]);
    drive(1'b1, bp_a[3], bp_b[3], 1'b0, bp_s[3]);
    @(negedge clk);
    chk_out("bp_out2", bp_e[2]);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("bp_out3", bp_e[3]);
    @(negedge clk);
    chk1("bp_empty", out_valid, 1'b0);

    // Reset with two bundles in flight.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk1("rst_mid_pre", out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    chk1("rst_mid_valid", out_valid, 1'b0);
    chk32("rst_mid_p", p, 32'd0);
    chk32("rst_mid_c", c, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rst_mid_stale", out_valid, 1'b0);
    end

    // Random stream with random stalls on both sides, scoreboard ordered.
    sent = 0;
    cyc = 0;
    while ((sent < 400 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 32'd0);
      if (sent < 400 && $urandom_range(0, 3) != 32'd0)
        drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk1("rnd_extra", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk_out("rnd", e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    chk1("rnd_drained", (sent == 400) && (q.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
